// File: rtl/aes_cbc_ctrl_if.sv
// Shared AES core request/response types and the command/result handshake
// interface of aes_cbc_ctrl.
package aes_cbc_pkg;
    localparam int AES_DATA_W = 128;
    localparam int AES_KEY_W  = 128;

    typedef enum logic [1:0] {
        FUNC_NONE = 2'd0,
        FUNC_KEY  = 2'd1,
        FUNC_ENC  = 2'd2,
        FUNC_DEC  = 2'd3
    } aes_func_e;

    typedef enum logic [1:0] {
        OP_KEY = 2'd0,
        OP_IV  = 2'd1,
        OP_ENC = 2'd2,
        OP_DEC = 2'd3
    } cmd_op_e;

    typedef struct packed {
        logic [AES_KEY_W-1:0]  key;
        logic [AES_DATA_W-1:0] data;
        aes_func_e             func;
        logic                  enable;
    } aes_in_type;

    typedef struct packed {
        logic [AES_DATA_W-1:0] result;
        logic                  ready;
    } aes_out_type;
endpackage

interface aes_cbc_ctrl_if #(
    parameter int DATA_W = aes_cbc_pkg::AES_DATA_W,
    parameter int KEY_W  = aes_cbc_pkg::AES_KEY_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic              cmd_mode;
    logic [KEY_W-1:0]  cmd_key;
    logic [DATA_W-1:0] cmd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err;

    modport master (
        output cmd_valid, cmd_op, cmd_mode, cmd_key, cmd_data, out_ready,
        input  cmd_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_mode, cmd_key, cmd_data, out_ready,
        output cmd_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/aes_cbc_ctrl.sv
// CBC block-mode sequencer in front of the AES core; define AES_CTR_MODE_EN
// to add CTR mode (cmd_mode=1) sharing the same chain register.
module aes_cbc_ctrl
    import aes_cbc_pkg::*;
#(
    // Must match the core's widths, which fix the aes_in/aes_out struct fields.
    parameter int DATA_W = AES_DATA_W,
    parameter int KEY_W  = AES_KEY_W
) (
    input  logic              clk,
    input  logic              rst,
    aes_cbc_ctrl_if.slave     cmd,
    output aes_in_type        aes_in,
    input  aes_out_type       aes_out
);

    typedef enum logic [2:0] {S_IDLE, S_KEY, S_RUN, S_WAIT, S_OUT} state_e;

    state_e            state;
    logic [DATA_W-1:0] chain;
    logic [DATA_W-1:0] in_reg;
    logic              key_loaded;
    logic              is_dec;
    logic [DATA_W-1:0] run_data;
    aes_func_e         run_func;
    logic [DATA_W-1:0] done_data;
    logic [DATA_W-1:0] next_chain;

`ifdef AES_CTR_MODE_EN
    logic              is_ctr;
`else
    logic              unused_mode;
    assign unused_mode = cmd.cmd_mode;
`endif

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        run_func = FUNC_ENC;
        run_data = cmd.cmd_data ^ chain;
        if (cmd.cmd_op == OP_DEC) begin
            run_func = FUNC_DEC;
            run_data = cmd.cmd_data;
        end
`ifdef AES_CTR_MODE_EN
        if (cmd.cmd_mode) begin
            run_func = FUNC_ENC;
            run_data = chain;
        end
`endif
    end

    always_comb begin
        done_data  = aes_out.result;
        next_chain = aes_out.result;
        if (is_dec) begin
            done_data  = aes_out.result ^ chain;
            next_chain = in_reg;
        end
`ifdef AES_CTR_MODE_EN
        // Counter lives in the low word only; the carry out of bit 31 is dropped.
        if (is_ctr) begin
            done_data  = aes_out.result ^ in_reg;
            next_chain = {chain[DATA_W-1:32], chain[31:0] + 32'd1};
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, and the
    // asynchronous reset clears every register including the wide data ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            cmd.cmd_ready <= 1'b0;
            cmd.out_valid <= 1'b0;
            cmd.out_data  <= '0;
            cmd.out_err   <= 1'b0;
            aes_in        <= '0;
            chain         <= '0;
            in_reg        <= '0;
            key_loaded    <= 1'b0;
            is_dec        <= 1'b0;
`ifdef AES_CTR_MODE_EN
            is_ctr        <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    cmd.cmd_ready <= 1'b1;
                    if (cmd.cmd_valid && cmd.cmd_ready) begin
                        case (cmd_op_e'(cmd.cmd_op))
                            OP_KEY: begin
                                aes_in.key    <= cmd.cmd_key;
                                aes_in.func   <= FUNC_KEY;
                                aes_in.enable <= 1'b1;
                                cmd.cmd_ready <= 1'b0;
                                state         <= S_KEY;
                            end
                            OP_IV: chain <= cmd.cmd_data;
                            default: begin
                                cmd.cmd_ready <= 1'b0;
                                if (!key_loaded) begin
                                    cmd.out_data  <= '0;
                                    cmd.out_err   <= 1'b1;
                                    cmd.out_valid <= 1'b1;
                                    state         <= S_OUT;
                                end else begin
                                    in_reg        <= cmd.cmd_data;
                                    is_dec        <= (cmd.cmd_op == OP_DEC);
`ifdef AES_CTR_MODE_EN
                                    is_ctr        <= cmd.cmd_mode;
`endif
                                    aes_in.key    <= '0;
                                    aes_in.data   <= run_data;
                                    aes_in.func   <= run_func;
                                    aes_in.enable <= 1'b1;
                                    state         <= S_RUN;
                                end
                            end
                        endcase
                    end
                end
                S_KEY: begin
                    aes_in        <= '0;
                    key_loaded    <= 1'b1;
                    cmd.cmd_ready <= 1'b1;
                    state         <= S_IDLE;
                end
                S_RUN: begin
                    aes_in.enable <= 1'b0;
                    state         <= S_WAIT;
                end
                S_WAIT: begin
                    if (aes_out.ready) begin
                        cmd.out_data  <= done_data;
                        chain         <= next_chain;
                        cmd.out_err   <= 1'b0;
                        cmd.out_valid <= 1'b1;
                        state         <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (cmd.out_ready) begin
                        cmd.out_valid <= 1'b0;
                        cmd.cmd_ready <= 1'b1;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// Self-checking bench for aes_cbc_ctrl: behavioural AES-128 core model,
// CBC/CTR reference model and a queue-based output scoreboard.
module tb_aes_cbc_ctrl;
    import aes_cbc_pkg::*;

    typedef struct {
        logic [127:0] data;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_cbc_ctrl_if #(.DATA_W(AES_DATA_W), .KEY_W(AES_KEY_W)) bus ();
    aes_in_type  aes_in;
    aes_out_type aes_out;

    aes_cbc_ctrl #(.DATA_W(AES_DATA_W), .KEY_W(AES_KEY_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd     (bus.slave),
        .aes_in  (aes_in),
        .aes_out (aes_out)
    );

    int tests = 0;
    int fails = 0;
    exp_t exp_q[$];

    logic [7:0]   sbox[256];
    logic [7:0]   inv_sbox[256];
    logic [127:0] ref_key, ref_chain;
    bit           ref_kl;
    logic [127:0] core_key = '0;
    logic [127:0] last_core_data = '0;
    int           enable_count = 0;
    bit           long_latency = 1'b0;
    int           ready_mode = 2;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- AES-128 reference ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic init_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x]     = s;
            inv_sbox[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? inv_sbox[s[127-8*i -: 8]] : sbox[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                int a;
                int b;
                a = r + 4 * c;
                b = r + 4 * ((c + r) % 4);
                if (inv) o[127-8*b -: 8] = s[127-8*a -: 8];
                else     o[127-8*a -: 8] = s[127-8*b -: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [7:0]   m[4];
        logic [7:0]   a[4];
        logic [7:0]   v;
        if (inv) m = '{8'd14, 8'd11, 8'd13, 8'd9};
        else     m = '{8'd2, 8'd3, 8'd1, 8'd1};
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127-8*(4*c+k) -: 8];
            for (int r = 0; r < 4; r++) begin
                v = '0;
                for (int k = 0; k < 4; k++) v ^= gmul(a[k], m[(k - r + 4) % 4]);
                o[127-8*(4*c+r) -: 8] = v;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] key, input int n);
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] s = pt ^ round_key(key, 0);
        for (int r = 1; r < 10; r++)
            s = mix_columns(shift_rows(sub_bytes(s, 0), 0), 0) ^ round_key(key, r);
        return shift_rows(sub_bytes(s, 0), 0) ^ round_key(key, 10);
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] key, input logic [127:0] ct);
        logic [127:0] s = ct ^ round_key(key, 10);
        for (int r = 9; r >= 1; r--) begin
            s = sub_bytes(shift_rows(s, 1), 1) ^ round_key(key, r);
            s = mix_columns(s, 1);
        end
        return sub_bytes(shift_rows(s, 1), 1) ^ round_key(key, 0);
    endfunction

    // ---------------- block-mode reference ----------------
    task automatic model_step(input logic [1:0] op, input bit mode, input logic [127:0] key,
                              input logic [127:0] data, output exp_t e, output bit has_out);
        has_out = 1'b0;
        e.data  = '0;
        e.err   = 1'b0;
        case (op)
            2'd0: begin ref_key = key; ref_kl = 1'b1; end
            2'd1: ref_chain = data;
            default: begin
                has_out = 1'b1;
                if (!ref_kl) begin
                    e.err = 1'b1;
                end
`ifdef AES_CTR_MODE_EN
                else if (mode) begin
                    e.data = aes_enc(ref_key, ref_chain) ^ data;
                    ref_chain[31:0] = ref_chain[31:0] + 32'd1;
                end
`endif
                else if (op == 2'd2) begin
                    e.data    = aes_enc(ref_key, data ^ ref_chain);
                    ref_chain = e.data;
                end else begin
                    e.data    = aes_dec(ref_key, data) ^ ref_chain;
                    ref_chain = data;
                end
            end
        endcase
    endtask

    // ---------------- AES core model ----------------
    initial begin
        int           cnt;
        bit           pend;
        bit           expect_valid;
        logic [127:0] res;
        cnt = 0; pend = 1'b0; expect_valid = 1'b0; res = '0;
        aes_out = '0;
        forever begin
            @(negedge clk);
            if (expect_valid && rst) check("out_valid_latency", 128'(bus.out_valid), 128'd1);
            expect_valid  = 1'b0;
            aes_out.ready = 1'b0;
            if (!rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        aes_out.result = res;
                        aes_out.ready  = 1'b1;
                        pend           = 1'b0;
                        expect_valid   = 1'b1;
                    end
                end
                if (aes_in.enable) begin
                    enable_count++;
                    if (aes_in.func == FUNC_KEY) begin
                        core_key = aes_in.key;
                    end else begin
                        last_core_data = aes_in.data;
                        res  = (aes_in.func == FUNC_DEC) ? aes_dec(core_key, aes_in.data)
                                                         : aes_enc(core_key, aes_in.data);
                        pend = 1'b1;
                        cnt  = long_latency ? 8 : int'($urandom_range(1, 4));
                    end
                end
            end
        end
    end

    // ---------------- downstream ready driver ----------------
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.out_ready = 1'($urandom_range(0, 1));
                1:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- output monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 128'd1, 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", bus.out_data, e.data);
                    check("out_err", 128'(bus.out_err), 128'(e.err));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [1:0] op, input bit mode, input logic [127:0] key,
                        input logic [127:0] data, input bit use_lit = 1'b0,
                        input logic [127:0] lit = '0);
        bit   acc;
        bit   kl_before;
        bit   has_out;
        exp_t e;
        acc = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_mode  = mode;
        bus.cmd_key   = key;
        bus.cmd_data  = data;
        for (int i = 0; i < 300; i++) begin
            if (bus.cmd_ready) begin acc = 1'b1; break; end
            @(negedge clk);
        end
        if (!acc) begin
            check("cmd_accept_timeout", 128'd0, 128'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        kl_before = ref_kl;
        model_step(op, mode, key, data, e, has_out);
        if (has_out) begin
            if (use_lit) e.data = lit;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (op == 2'd0) begin
            check("key_enable", 128'(aes_in.enable), 128'd1);
            check("key_func", 128'(aes_in.func), 128'd1);
        end else if (op != 2'd1) begin
            if (kl_before) check("run_enable", 128'(aes_in.enable), 128'd1);
            else           check("err_no_enable", 128'(aes_in.enable), 128'd0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0) return;
            @(negedge clk);
        end
        check("drain_timeout", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] k1, p1, c1, c2, rd;
        logic [1:0]   op;
        int           r;
        bit           seen;
        k1 = 128'h000102030405060708090a0b0c0d0e0f;
        p1 = 128'h00112233445566778899aabbccddeeff;
        c1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        init_tables();
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_mode = 1'b0;
        bus.cmd_key = '0; bus.cmd_data = '0;
        ref_key = '0; ref_chain = '0; ref_kl = 1'b0;

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 128'(bus.cmd_ready), 128'd0);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_out_data", bus.out_data, 128'd0);
        check("rst_out_err", 128'(bus.out_err), 128'd0);
        check("rst_aes_en", 128'(aes_in.enable), 128'd0);
        check("rst_aes_data", aes_in.data, 128'd0);
        check("rst_aes_key", aes_in.key, 128'd0);
        check("rst_aes_func", 128'(aes_in.func), 128'd0);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_cmd_ready", 128'(bus.cmd_ready), 128'd1);
        check("idle_out_valid", 128'(bus.out_valid), 128'd0);
        check("idle_no_enable", 128'(enable_count), 128'd0);

        // Block before any key: error result and no core activity.
        send(2'd2, 1'b0, '0, 128'h1);
        drain();
        check("nokey_enable_count", 128'(enable_count), 128'd0);

        // FIPS-197 vector, then chained block whose core input is zero.
        send(2'd0, 1'b0, k1, '0);
        send(2'd1, 1'b0, '0, '0);
        send(2'd2, 1'b0, '0, p1, 1'b1, c1);
        send(2'd2, 1'b0, '0, c1);
        drain();
        check("chain_core_data_zero", last_core_data, 128'd0);
        c2 = aes_enc(k1, 128'd0);

        send(2'd1, 1'b0, '0, '0);
        send(2'd3, 1'b0, '0, c1, 1'b1, p1);
        send(2'd3, 1'b0, '0, c2, 1'b1, c1);
        drain();

        // Downstream stall: output and backpressure held for 5 cycles.
        ready_mode = 1;
        send(2'd2, 1'b0, '0, p1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.out_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("stall_valid_seen", 128'(seen), 128'd1);
        for (int i = 0; i < 5; i++) begin
            if (exp_q.size() != 0) check("stall_out_data", bus.out_data, exp_q[0].data);
            check("stall_cmd_ready", 128'(bus.cmd_ready), 128'd0);
            check("stall_out_valid", 128'(bus.out_valid), 128'd1);
            @(negedge clk);
        end
        ready_mode = 2;
        drain();

`ifdef AES_CTR_MODE_EN
        send(2'd1, 1'b0, '0, 128'h0000_0000_0000_0000_0000_0000_ffff_ffff);
        send(2'd2, 1'b1, '0, {$urandom, $urandom, $urandom, $urandom});
        drain();
        check("ctr_first_core_data", last_core_data, 128'h0000_0000_0000_0000_0000_0000_ffff_ffff);
        send(2'd3, 1'b1, '0, {$urandom, $urandom, $urandom, $urandom});
        drain();
        check("ctr_wrap_core_data", last_core_data, 128'd0);
`endif

        // Randomised command mix with random downstream backpressure.
        ready_mode = 0;
        for (int n = 0; n < 60; n++) begin
            r  = int'($urandom_range(0, 9));
            op = (r == 0) ? 2'd0 : (r == 1) ? 2'd1 : (r < 6) ? 2'd2 : 2'd3;
            send(op, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom});
        end
        drain();

        // Reset while the core is busy: no output, key and chain forgotten.
        ready_mode   = 2;
        long_latency = 1'b1;
        send(2'd2, 1'b0, '0, p1);
        @(negedge clk);
        check("wait_no_valid", 128'(bus.out_valid), 128'd0);
        rst = 1'b0;
        #1;
        check("abort_out_valid", 128'(bus.out_valid), 128'd0);
        check("abort_cmd_ready", 128'(bus.cmd_ready), 128'd0);
        exp_q.delete();
        ref_chain = '0; ref_kl = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        long_latency = 1'b0;
        repeat (2) @(negedge clk);
        check("post_abort_cmd_ready", 128'(bus.cmd_ready), 128'd1);
        check("post_abort_out_valid", 128'(bus.out_valid), 128'd0);
        send(2'd2, 1'b0, '0, p1);
        send(2'd0, 1'b0, k1, '0);
        send(2'd2, 1'b0, '0, p1, 1'b1, c1);
        drain();
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_cbc_ctrl.md
Name: aes_cbc_ctrl

Overview:
- Block-mode controller placed directly upstream of the AES core (`aes` or `aes_state`).
- Accepts key, IV and data-block commands through a valid/ready handshake.
- Sequences the core's key-expansion, encrypt and decrypt operations over the core's `aes_in_type`/`aes_out_type` interface.
- Applies CBC chaining and returns result blocks through a valid/ready output handshake.

Parameters:
- DATA_W, 32*Nb, block width in bits; must equal the core's data width.
- KEY_W, 32*Nk, key width in bits; must equal the core's key width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_op  in  2  0=load key, 1=load IV, 2=encrypt block, 3=decrypt block
- cmd_mode  in  1  0=CBC, 1=CTR (see Optional Feature)
- cmd_key  in  KEY_W  key, used for op 0 only
- cmd_data  in  DATA_W  IV for op 1; plaintext or ciphertext for ops 2/3
- out_valid  out  1  result block present
- out_ready  in  1  downstream accepts the result
- out_data  out  DATA_W  result block
- out_err  out  1  block was rejected because no key is loaded
- aes_in  out  aes_in_type  core request: key, data, func (1=key, 2=enc, 3=dec), enable
- aes_out  in  aes_out_type  core response: result, ready

Behaviour:
- Reset (rst=0, asynchronous): all outputs and registers go to 0.
  - cmd_ready=0; out_valid=0; out_data=0; out_err=0; aes_in all fields 0.
  - chain register=0; key_loaded=0; state=IDLE.
  - Reset mid-operation aborts silently. No output is produced and the chain is lost.
- FSM states: IDLE, KEY, RUN, WAIT, OUT.
- IDLE:
  - cmd_ready=1 in IDLE only.
  - On handshake with op 0: go to KEY.
  - On handshake with op 1: chain<=cmd_data, stay IDLE, no output.
  - On handshake with op 2/3 and key_loaded=0: out_data<=0, out_err<=1, go to OUT.
  - On handshake with op 2/3 otherwise: latch the block into in_reg, go to RUN.
- KEY:
  - For one cycle: aes_in.key=cmd_key (latched), func=1, enable=1.
  - Set key_loaded=1, return to IDLE.
  - Key load does not wait for core ready.
- RUN: one cycle with enable=1, key=0, then go to WAIT.
  - CBC encrypt: data=in_reg^chain, func=2.
  - CBC decrypt: data=in_reg, func=3.
- WAIT:
  - enable=0; aes_in.data and aes_in.func are held.
  - When aes_out.ready=1:
    - Encrypt: out_data<=result; chain<=result.
    - Decrypt: out_data<=result^chain; chain<=in_reg.
    - Set out_err<=0 and go to OUT.
  - aes_out.ready seen in any other state is ignored.
- OUT:
  - out_valid=1; out_data and out_err are held stable until out_ready=1.
  - On out_ready=1: out_valid<=0, go to IDLE.
  - A new command is accepted no earlier than the cycle after the output handshake.
- Latency: command accept at cycle T; core enable at T+1; out_valid on the cycle after core ready.
- XOR is a bitwise full-width DATA_W operation. No arithmetic is performed in CBC.
- A key reload (op 0) does not clear the chain. An IV reload (op 1) does not clear key_loaded.
- cmd_mode is ignored when AES_CTR_MODE_EN is undefined.

Optional Feature:
- Macro: AES_CTR_MODE_EN.
- When defined, cmd_mode=1 on op 2/3 selects CTR mode:
  - RUN issues func=2 with data=chain, for both encrypt and decrypt.
  - On core ready: out_data<=result^in_reg.
  - chain[31:0]<=chain[31:0]+1, wrapping ffffffff->00000000 with no carry into bit 32; the upper bits are unchanged.
  - CBC and CTR share the chain register, which is loaded by op 1.
- When undefined: no counter logic exists and all blocks use CBC.

Test Plan:
- Reset then hold: cmd_ready=1 and out_valid=0, aes_in.enable is never asserted, and asserting rst mid-WAIT returns to IDLE with out_valid=0.
- Encrypt before any key (op 2, data=1): out_valid=1, out_err=1, out_data=0, and no core enable pulse occurs.
- AES-128 build: key 000102030405060708090a0b0c0d0e0f, IV=0, encrypt 00112233445566778899aabbccddeeff -> out_data=69c4e0d86a7b0430d8cdb78070b4c55a.
- Continue with block 69c4e0d86a7b0430d8cdb78070b4c55a -> the core sees data=0, and out_data equals the model's encryption of 0.
- Reload IV=0 and decrypt both ciphertexts in order -> the original two plaintexts are returned.
- Hold out_ready=0 for 5 cycles in OUT -> out_data is stable and cmd_ready=0 throughout.
- AES_CTR_MODE_EN, IV=000...0ffffffff, two CTR blocks -> the second core data is 000...000000000, with no carry into bit 32.
